// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the pipeline MEM stage.
// Accepts one load/store at a time, inserts WAIT_STATES wait cycles, then
// emits a one-cycle response with RV32I-sized and extended load data.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (misaligned accesses
// are flagged with rsp_err instead of being forced to natural alignment).
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept, go_resp, mem_we, mis;
    logic          eff_we;
    logic [31:0]   eff_addr, eff_wdata, acc_addr;
    logic [2:0]    eff_f3;
    logic [1:0]    size, off;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wdata_sh, rd_word, rd_sh;
    logic          unused_addr_bits;

    // Size/extend a right-aligned load word according to funct3; unsupported codes act as word.
    function automatic logic [31:0] load_extend(input logic [31:0] sh, input logic [2:0] f3);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        ext;
        b   = sh[7:0];
        h   = sh[15:0];
        ext = sh;
        if (f3[1:0] == 2'b00) begin
            ext = f3[2] ? {24'd0, sh[7:0]} : 32'(b);
        end else if (f3[1:0] == 2'b01) begin
            ext = f3[2] ? {16'd0, sh[15:0]} : 32'(h);
        end
        return ext;
    endfunction

    // Select the live request (incoming in IDLE, latched otherwise) and decode lanes.
    always_comb begin
        accept = (state_q == S_IDLE) && req_valid && reset;
        if (state_q == S_IDLE) begin
            eff_we    = req_we;
            eff_addr  = req_addr;
            eff_wdata = req_wdata;
            eff_f3    = req_funct3;
        end else begin
            eff_we    = we_q;
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
            eff_f3    = f3_q;
        end
        size = (eff_f3[1:0] == 2'b00) ? 2'd0 : (eff_f3[1:0] == 2'b01) ? 2'd1 : 2'd2;
        acc_addr = eff_addr;
`ifdef DMEM_MISALIGN_CHECK_EN
        mis = ((size == 2'd1) && eff_addr[0]) || ((size == 2'd2) && (eff_addr[1:0] != 2'b00));
`else
        mis = 1'b0;
        if (size == 2'd1) begin
            acc_addr[0] = 1'b0;
        end else if (size == 2'd2) begin
            acc_addr[1:0] = 2'b00;
        end
`endif
        off      = acc_addr[1:0];
        idx      = acc_addr[AW+1:2];
        be       = (size == 2'd0) ? (4'b0001 << off) : (size == 2'd1) ? (4'b0011 << off) : 4'b1111;
        wdata_sh = eff_wdata << {off, 3'b000};
        rd_word  = mem[idx];
        rd_sh    = rd_word >> {off, 3'b000};
        go_resp  = (accept && (WAIT_STATES == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd0));
        mem_we   = go_resp && eff_we && !mis;
    end

    assign unused_addr_bits = ^acc_addr[31:AW+2];

    // Next-state, wait counter, request latch and response register values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    f3_d    = req_funct3;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (go_resp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = mis;
            rsp_rdata_d = (eff_we || mis) ? 32'd0 : load_extend(rd_sh, eff_f3);
        end
    end

    // Control and response registers; async reset abandons any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            f3_q        <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-lane store on the edge entering RESP; storage is never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = reset && (state_q == S_IDLE);
    assign stall     = reset && (((state_q == S_IDLE) && req_valid) || (state_q == S_WAIT));
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state and
// one with none, exercising sizing, extension, wrap, reset abort and alignment.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        v0, v1;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [2:0]  r_f3;

    logic        rdy0, rv0, er0, st0;
    logic [31:0] rd0;
    logic        rdy1, rv1, er1, st1;
    logic [31:0] rd1;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_we(r_we),
        .req_addr(r_addr), .req_wdata(r_wdata), .req_funct3(r_f3),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0), .stall(st0)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_we(r_we),
        .req_addr(r_addr), .req_wdata(r_wdata), .req_funct3(r_f3),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1), .stall(st1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    function automatic logic sel_rv(input int sel);
        return (sel == 0) ? rv0 : rv1;
    endfunction
    function automatic logic sel_st(input int sel);
        return (sel == 0) ? st0 : st1;
    endfunction
    function automatic logic sel_rdy(input int sel);
        return (sel == 0) ? rdy0 : rdy1;
    endfunction
    function automatic logic [31:0] sel_rd(input int sel);
        return (sel == 0) ? rd0 : rd1;
    endfunction
    function automatic logic sel_er(input int sel);
        return (sel == 0) ? er0 : er1;
    endfunction

    // One full request: checks ready, latency, stall length, data, error and pulse width.
    task automatic do_req(input int sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int ws, lat, stc;
        ws = (sel == 0) ? 0 : 1;
        @(negedge clk);
        r_we = we; r_addr = addr; r_wdata = wdata; r_f3 = f3;
        if (sel == 0) v0 = 1'b1; else v1 = 1'b1;
        #1;
        chk({tag, ".ready"}, 32'(sel_rdy(sel)), 32'd1);
        stc = sel_st(sel) ? 1 : 0;
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (sel_rv(sel)) begin
                lat = i;
                break;
            end
            if (sel_st(sel)) stc++;
            @(posedge clk); #1;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(ws + 1));
        chk({tag, ".stall_cycles"}, 32'(stc), 32'(ws + 1));
        chk({tag, ".stall_at_rsp"}, 32'(sel_st(sel)), 32'd0);
        chk({tag, ".rdata"}, sel_rd(sel), exp_rd);
        chk({tag, ".err"}, 32'(sel_er(sel)), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, ".pulse_end"}, 32'(sel_rv(sel)), 32'd0);
        chk({tag, ".rdata_hold"}, sel_rd(sel), exp_rd);
    endtask

    initial begin
        reset = 1'b0;
        v0 = 1'b0; v1 = 1'b1;
        r_we = 1'b0; r_addr = 32'd0; r_wdata = 32'd0; r_f3 = 3'b010;
        #3;
        chk("rst.ready1", 32'(rdy1), 32'd0);
        chk("rst.stall1", 32'(st1), 32'd0);
        chk("rst.ready0", 32'(rdy0), 32'd0);
        chk("rst.rsp_valid1", 32'(rv1), 32'd0);
        chk("rst.rdata1", rd1, 32'd0);
        chk("rst.err1", 32'(er1), 32'd0);
        chk("rst.rdata0", rd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        v1 = 1'b0;
        reset = 1'b1;

        // One wait state: word store then load.
        do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, "sw10");
        do_req(1, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, "lw10");
        do_req(1, 1'b0, 32'h10, 32'h0, 3'b011, 32'hDEADBEEF, 1'b0, "f3_011_word");

        // Byte store over existing word, then word/byte loads.
        do_req(1, 1'b1, 32'h20, 32'h11223344, 3'b010, 32'h0, 1'b0, "sw20");
        do_req(1, 1'b1, 32'h21, 32'h00000080, 3'b000, 32'h0, 1'b0, "sb21");
        do_req(1, 1'b0, 32'h20, 32'h0, 3'b010, 32'h11228044, 1'b0, "lw20");
        do_req(1, 1'b0, 32'h21, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, "lb21");
        do_req(1, 1'b0, 32'h21, 32'h0, 3'b100, 32'h00000080, 1'b0, "lbu21");

        // Zero wait states: halfword store and extended loads.
        do_req(0, 1'b1, 32'h42, 32'h0000BEEF, 3'b001, 32'h0, 1'b0, "sh42");
        do_req(0, 1'b0, 32'h42, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0, "lh42");
        do_req(0, 1'b0, 32'h42, 32'h0, 3'b101, 32'h0000BEEF, 1'b0, "lhu42");

        // Address wrap modulo 1 KiB.
        do_req(1, 1'b1, 32'h400, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, "sw400");
        do_req(1, 1'b0, 32'h0, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, "lw0_wrap");

        // Reset while a store waits: it must be dropped with no response.
        do_req(1, 1'b1, 32'h30, 32'h0, 3'b010, 32'h0, 1'b0, "sw30_clear");
        @(negedge clk);
        r_we = 1'b1; r_addr = 32'h30; r_wdata = 32'h12345678; r_f3 = 3'b010; v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
        chk("abort.in_wait_stall", 32'(st1), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("abort.rsp_valid_now", 32'(rv1), 32'd0);
        chk("abort.stall_now", 32'(st1), 32'd0);
        @(posedge clk); #1;
        chk("abort.rsp_valid_edge", 32'(rv1), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort.no_late_rsp", 32'(rv1), 32'd0);
        end
        chk("abort.ready_after", 32'(rdy1), 32'd1);
        do_req(1, 1'b0, 32'h30, 32'h0, 3'b010, 32'h0, 1'b0, "lw30_after_abort");

        // Misaligned word store.
        do_req(1, 1'b1, 32'h50, 32'h0, 3'b010, 32'h0, 1'b0, "sw50_clear");
`ifdef DMEM_MISALIGN_CHECK_EN
        do_req(1, 1'b1, 32'h52, 32'hFFFFFFFF, 3'b010, 32'h0, 1'b1, "sw52_mis");
        do_req(1, 1'b0, 32'h50, 32'h0, 3'b010, 32'h0, 1'b0, "lw50_unchanged");
`else
        do_req(1, 1'b1, 32'h52, 32'hFFFFFFFF, 3'b010, 32'h0, 1'b0, "sw52_forced");
        do_req(1, 1'b0, 32'h50, 32'h0, 3'b010, 32'hFFFFFFFF, 1'b0, "lw50_forced");
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
